// File: rtl/vga_timing_rx.sv
// Parallel-video receiver: recovers pixel coordinates from Vsync/DE, measures the active
// raster and declares lock once consecutive frames agree.
`timescale 1ns/1ps
module vga_timing_rx #(
   parameter bit          VS_POL      = 1'b1,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned MAX_W       = 1024,
   parameter int unsigned MAX_H       = 768
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        iHsync,
   input  logic        iVsync,
   input  logic        iDE,
   input  logic [7:0]  iR,
   input  logic [7:0]  iG,
   input  logic [7:0]  iB,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic        sof,
   output logic        eol,
   output logic [10:0] h_active,
   output logic [9:0]  v_active,
   output logic        locked,
   output logic        err
);

   typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

   localparam logic [10:0] MaxW  = 11'(MAX_W);
   localparam logic [9:0]  MaxH  = 10'(MAX_H);
   localparam logic [3:0]  LockN = 4'(LOCK_FRAMES);

   state_e      state;
   logic        hsync_unused;
   logic        vs_d, vs_q, de_d, de_q;
   logic [7:0]  r_d, g_d, b_d;
   logic        vs_rise, de_fall;
   logic [10:0] x_cnt, x_inc, x_cur, line_w, lw_end;
   logic [9:0]  y_cnt, y_inc, y_cur, y_end;
   logic        frame_bad, bad_end;
   logic [3:0]  match_cnt, match_nxt;

   assign hsync_unused = iHsync;

   // *_end values fold in a line that closes in the same cycle as vs_rise.
   always_comb begin
      vs_rise = vs_d & ~vs_q;
      de_fall = de_q & ~de_d;
      x_inc   = (x_cnt == 11'h7FF) ? x_cnt : x_cnt + 11'd1;
      y_inc   = (y_cnt == 10'h3FF) ? y_cnt : y_cnt + 10'd1;
      y_end   = de_fall ? y_inc : y_cnt;
      lw_end  = (de_fall && y_cnt == '0) ? x_cnt : line_w;
      bad_end = frame_bad || (x_cnt > MaxW) || (y_cnt > MaxH) ||
                (de_fall && y_cnt != '0 && x_cnt != line_w);
      x_cur   = vs_rise ? '0 : x_cnt;
      y_cur   = vs_rise ? '0 : y_cnt;
      match_nxt = 4'd1;
      if (lw_end == h_active && y_end == v_active) begin
         match_nxt = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_d      <= 1'b0;
         vs_q      <= 1'b0;
         de_d      <= 1'b0;
         de_q      <= 1'b0;
         r_d       <= '0;
         g_d       <= '0;
         b_d       <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         line_w    <= '0;
         frame_bad <= 1'b0;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         R         <= '0;
         G         <= '0;
         B         <= '0;
      end else if (en) begin
         vs_d <= (iVsync == VS_POL);
         vs_q <= vs_d;
         de_d <= iDE;
         de_q <= de_d;
         r_d  <= iR;
         g_d  <= iG;
         b_d  <= iB;
         if (vs_rise) begin
            frame_bad <= 1'b0;
            y_cnt     <= '0;
            x_cnt     <= de_d ? 11'd1 : 11'd0;
         end else begin
            frame_bad <= bad_end;
            line_w    <= lw_end;
            if (de_fall) begin
               x_cnt <= '0;
               y_cnt <= y_inc;
            end else if (de_d) begin
               x_cnt <= x_inc;
            end
         end
         pix_valid <= de_d;
         pix_x     <= de_d ? x_cur : '0;
         pix_y     <= de_d ? y_cur : '0;
         sof       <= de_d && x_cur == '0 && y_cur == '0;
         // iDE here is already the sample that follows the pixel in de_d
         eol       <= de_d & ~iDE;
         R         <= de_d ? r_d : '0;
         G         <= de_d ? g_d : '0;
         B         <= de_d ? b_d : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StSearch;
         match_cnt <= '0;
         h_active  <= '0;
         v_active  <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
      end else if (en) begin
         err <= 1'b0;
         unique case (state)
            StSearch: begin
               if (vs_rise) begin
                  state     <= StMeasure;
                  match_cnt <= '0;
               end
            end
            StMeasure: begin
               if (vs_rise) begin
                  if (bad_end) begin
                     err       <= 1'b1;
                     match_cnt <= '0;
                  end else if (y_end != '0) begin
                     h_active  <= lw_end;
                     v_active  <= y_end;
                     match_cnt <= match_nxt;
                     if (match_nxt >= LockN) begin
                        state  <= StLocked;
                        locked <= 1'b1;
                     end
                  end
               end
            end
            StLocked: begin
               if (vs_rise && (bad_end || lw_end != h_active || y_end != v_active)) begin
                  err       <= 1'b1;
                  locked    <= 1'b0;
                  match_cnt <= '0;
                  state     <= StMeasure;
               end
            end
            default: state <= StSearch;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx: a stimulus-side scoreboard checks every output pixel,
// directed checks cover reset, lock, relock, enable stalls and line overflow.
`timescale 1ns/1ps
module tb_vga_timing_rx;

   localparam int W = 720, H = 3, HBLANK = 8, VS_LEN = 4, VBP = 4;

   logic        clk = 1'b0, reset = 1'b1, en = 1'b0;
   logic        iHsync = 1'b0, iVsync = 1'b0, iDE = 1'b0;
   logic [7:0]  iR = '0, iG = '0, iB = '0;
   logic [7:0]  R, G, B;
   logic        pix_valid, sof, eol, locked, err;
   logic [10:0] pix_x, h_active;
   logic [9:0]  pix_y, v_active;

   always #5 clk = ~clk;

   vga_timing_rx dut (
      .clk(clk), .reset(reset), .en(en), .iHsync(iHsync), .iVsync(iVsync), .iDE(iDE),
      .iR(iR), .iG(iG), .iB(iB), .R(R), .G(G), .B(B), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .h_active(h_active),
      .v_active(v_active), .locked(locked), .err(err)
   );

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic [7:0]  r, g, b;
      logic        sof, eol;
      int unsigned cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned ecnt = 0;
   logic        en_last = 1'b0;
   bit          toggle = 1'b0;
   int          pix_err = 0, err_cnt = 0, sof_cnt = 0;
   int          max_x = 0, max_y = 0, last_eol_x = -1;
   int          n_checks = 0, n_pass = 0;
   int          err_base, sof_base;

   always @(posedge clk) begin
      en_last <= en;
      if (en) ecnt <= ecnt + 1;
   end

   // Pixel scoreboard: compares coordinates, data, flags and 2-en-cycle latency.
   always @(negedge clk) begin
      if (!reset && en_last) begin
         if (pix_valid) begin
            if (exp_q.size() == 0) begin
               pix_err++;
            end else begin
               mon_e = exp_q.pop_front();
               if (pix_x != mon_e.x || pix_y != mon_e.y || R != mon_e.r || G != mon_e.g ||
                   B != mon_e.b || sof != mon_e.sof || eol != mon_e.eol || ecnt != mon_e.cyc)
                  pix_err++;
            end
            if (int'(pix_x) > max_x) max_x = int'(pix_x);
            if (int'(pix_y) > max_y) max_y = int'(pix_y);
            if (eol) last_eol_x = int'(pix_x);
            if (sof) sof_cnt++;
         end else if (sof || eol || R != 0 || G != 0 || B != 0) begin
            pix_err++;
         end
         if (err) err_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      en = 1'b1;
      @(posedge clk); #1;
      if (toggle) begin
         en = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      iDE = 1'b0; iR = 8'hAA; iG = 8'h55; iB = 8'hFF;
      repeat (n) step();
   endtask

   task automatic drive_pixel(input int x, input int y, input int w);
      exp_t e;
      iDE = 1'b1;
      iR  = 8'(x);
      iG  = 8'(y * 37 + 5);
      iB  = 8'(x >> 3);
      e.x = 11'(x); e.y = 10'(y); e.r = iR; e.g = iG; e.b = iB;
      e.sof = (x == 0 && y == 0);
      e.eol = (x == w - 1);
      e.cyc = ecnt + 2;
      exp_q.push_back(e);
      step();
   endtask

   task automatic send_frame(input int odd_line, input int odd_w);
      iVsync = 1'b1; idle(VS_LEN);
      iVsync = 1'b0; idle(VBP);
      for (int l = 0; l < H; l++) begin
         for (int x = 0; x < ((l == odd_line) ? odd_w : W); x++)
            drive_pixel(x, l, (l == odd_line) ? odd_w : W);
         idle(HBLANK);
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1; iDE = 1'b0; iVsync = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_flags", {pix_valid, sof, eol, locked, err, pix_x, pix_y}, '0);
      check_eq("rst_data", {R, G, B, h_active, v_active}, '0);
      reset = 1'b0;
      idle(4);

      // Reset in the middle of an active line
      iVsync = 1'b1; idle(VS_LEN);
      iVsync = 1'b0; idle(VBP);
      for (int x = 0; x < 10; x++) drive_pixel(x, 0, W);
      @(negedge clk);
      check_eq("midline_valid", pix_valid, 1'b1);
      @(posedge clk); #1;
      reset = 1'b1; iDE = 1'b0;
      exp_q.delete();
      #1;
      check_eq("midline_rst_flags", {pix_valid, sof, eol, locked, err, pix_x, pix_y}, '0);
      check_eq("midline_rst_data", {R, G, B, h_active, v_active}, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Acquire lock on a clean stream
      err_base = err_cnt;
      sof_base = sof_cnt;
      send_frame(-1, 0);
      send_frame(-1, 0);
      check_eq("lock_after_2vs", locked, 1'b0);
      send_frame(-1, 0);
      check_eq("lock_after_3vs", locked, 1'b1);
      check_eq("h_active", h_active, 11'd720);
      check_eq("v_active", v_active, 10'd3);
      check_eq("acq_err", err_cnt - err_base, 0);

      // Coordinates and frame/line markers while locked
      send_frame(-1, 0);
      check_eq("still_locked", locked, 1'b1);
      check_eq("sof_count", sof_cnt - sof_base, 4);
      check_eq("last_eol_x", last_eol_x, 719);
      check_eq("max_y", max_y, 2);
      check_eq("max_x", max_x, 719);
      check_eq("pix_stream_a", pix_err, 0);

      // One short line: error at following vsync, relock after two clean frames
      err_base = err_cnt;
      send_frame(1, 719);
      check_eq("short_pre_lock", locked, 1'b1);
      check_eq("short_pre_err", err_cnt - err_base, 0);
      send_frame(-1, 0);
      check_eq("short_err", err_cnt - err_base, 1);
      check_eq("short_unlock", locked, 1'b0);
      send_frame(-1, 0);
      check_eq("relock_1clean", locked, 1'b0);
      send_frame(-1, 0);
      check_eq("relock_2clean", locked, 1'b1);
      check_eq("relock_err", err_cnt - err_base, 1);
      check_eq("pix_stream_b", pix_err, 0);

      // Enable toggling every cycle
      pulse_reset();
      check_eq("rst2_state", {locked, h_active, v_active}, '0);
      toggle = 1'b1;
      err_base = err_cnt;
      send_frame(-1, 0);
      send_frame(-1, 0);
      check_eq("en_lock_after_2vs", locked, 1'b0);
      send_frame(-1, 0);
      check_eq("en_lock_after_3vs", locked, 1'b1);
      check_eq("en_h_active", h_active, 11'd720);
      check_eq("en_v_active", v_active, 10'd3);
      check_eq("en_err", err_cnt - err_base, 0);
      check_eq("pix_stream_en", pix_err, 0);
      toggle = 1'b0;

      // Over-long line, first while locked then while measuring
      err_base = err_cnt;
      send_frame(1, 1100);
      check_eq("long_pre_lock", locked, 1'b1);
      send_frame(-1, 0);
      check_eq("long_err_locked", err_cnt - err_base, 1);
      check_eq("long_unlock", locked, 1'b0);
      check_eq("long_max_x", max_x, 1099);
      check_eq("long_h_hold", h_active, 11'd720);
      send_frame(1, 1100);
      check_eq("long_measure_nolock", locked, 1'b0);
      send_frame(-1, 0);
      check_eq("long_err_measure", err_cnt - err_base, 2);
      check_eq("long_still_unlocked", locked, 1'b0);
      check_eq("long_v_hold", v_active, 10'd3);
      check_eq("pix_stream_c", pix_err, 0);
      check_eq("drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
